// File: rtl/ldst_responder_pkg.sv
// Shared constants, FSM state type and address helpers for the load/store responder.
package ldst_responder_pkg;

  localparam logic [15:0] ADDR_LEDR   = 16'h2000;
  localparam logic [15:0] ADDR_CYCLES = 16'h2002;
  localparam logic [15:0] SLOW_BASE   = 16'h3000;
  localparam int          SLOW_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ldst_state_t;

  // Slow window is 8 words = 16 bytes, so only the upper 12 address bits decode it.
  function automatic logic is_slow(input logic [15:0] addr);
    return addr[15:4] == SLOW_BASE[15:4];
  endfunction

endpackage

// File: rtl/ldst_responder_if.sv
// Load/store port between the execute stage (master) and the data-side responder (slave).
// Handshake: a request (rd|wr) is accepted on a rising edge where waitrequest is low; while
// waitrequest is high the master holds addr/rd/wr/wrdata stable. rdvalid pulses for exactly one
// cycle, the cycle after an accepted load, with rddata; rddata holds its last value otherwise.
interface ldst_responder_if;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;
  logic        o_ldst_rdvalid;
  logic        o_ldst_waitrequest;

  modport master (
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    input  o_ldst_rddata, o_ldst_rdvalid, o_ldst_waitrequest
  );

  modport slave (
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    output o_ldst_rddata, o_ldst_rdvalid, o_ldst_waitrequest
  );
endinterface

// File: rtl/ldst_ram.sv
// Single-port synchronous data RAM, 16-bit words, registered read, write-first.
module ldst_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ldst_responder.sv
// Data-side responder: decodes the load/store port into RAM, LED/cycle-counter registers and a
// stalling scratch region, and returns load data one cycle after acceptance.
module ldst_responder
  import ldst_responder_pkg::*;
#(
  parameter int RAM_WORDS   = 4096,
  parameter int WAIT_STATES = 2,
  parameter int LED_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  ldst_responder_if.slave      ldst,
  output logic [LED_WIDTH-1:0] o_ledr,
  output ldst_state_t          dbg_state
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);

  logic [15:0] addr;
  logic [14:0] word_addr;
  logic        ram_hit, led_hit, cyc_hit, slow_hit;
  logic        req, accept, do_wr, do_rd, wait_req;
  logic        unused_addr_bit;

  ldst_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [15:0] cycles;
  logic [15:0] scratch [SLOW_WORDS];
  logic [15:0] reg_rdata, reg_q, hold_q, ram_rdata, rddata;
  logic        rdvalid_q, from_ram;

  assign addr            = ldst.i_ldst_addr;
  assign word_addr       = addr[15:1];
  assign unused_addr_bit = addr[0];

  assign ram_hit  = {1'b0, addr} < RAM_BYTES;
  assign led_hit  = word_addr == ADDR_LEDR[15:1];
  assign cyc_hit  = word_addr == ADDR_CYCLES[15:1];
  assign slow_hit = is_slow(addr);

  assign req    = ldst.i_ldst_rd | ldst.i_ldst_wr;
  assign accept = req & ~wait_req;
  // A combined rd+wr is treated as a store; the read half is dropped.
  assign do_wr  = accept & ldst.i_ldst_wr;
  assign do_rd  = accept & ldst.i_ldst_rd & ~ldst.i_ldst_wr;

  // Stall counts the request cycle itself, so WAIT lasts WAIT_STATES-1 cycles.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wait_req = 1'b0;
    case (state)
      IDLE: begin
        if ((WAIT_STATES > 0) && req && slow_hit) begin
          wait_req = 1'b1;
          if (WAIT_STATES == 1) begin
            state_n = DONE;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
        end else begin
          wait_req = 1'b1;
          cnt_n    = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (led_hit)       reg_rdata = 16'(o_ledr);
    else if (cyc_hit)  reg_rdata = cycles;
    else if (slow_hit) reg_rdata = scratch[addr[3:1]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ledr    <= '0;
      cycles    <= '0;
      for (int i = 0; i < SLOW_WORDS; i++) scratch[i] <= '0;
      rdvalid_q <= 1'b0;
      from_ram  <= 1'b0;
      reg_q     <= '0;
      hold_q    <= '0;
    end else begin
      cycles    <= (do_wr && cyc_hit) ? 16'h0000 : cycles + 16'd1;
      if (do_wr && led_hit)  o_ledr <= ldst.i_ldst_wrdata[LED_WIDTH-1:0];
      if (do_wr && slow_hit) scratch[addr[3:1]] <= ldst.i_ldst_wrdata;
      rdvalid_q <= do_rd;
      if (do_rd) begin
        from_ram <= ram_hit;
        reg_q    <= reg_rdata;
      end
      hold_q    <= rddata;
    end
  end

  ldst_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (accept & ram_hit),
    .we    (ldst.i_ldst_wr),
    .addr  (addr[RAM_AW:1]),
    .wdata (ldst.i_ldst_wrdata),
    .rdata (ram_rdata)
  );

  assign rddata                  = rdvalid_q ? (from_ram ? ram_rdata : reg_q) : hold_q;
  assign ldst.o_ldst_rddata      = rddata;
  assign ldst.o_ldst_rdvalid     = rdvalid_q;
  assign ldst.o_ldst_waitrequest = wait_req;
  assign dbg_state               = state;

endmodule

// File: tb/tb_ldst_responder.sv
// Directed and randomized bench for ldst_responder against an address-map reference model.
module tb_ldst_responder;
  import ldst_responder_pkg::*;

  localparam int WS = 2;

  logic        clk;
  logic        reset;
  logic [9:0]  ledr;
  ldst_state_t dbg_state;

  ldst_responder_if ldst ();

  ldst_responder #(
    .RAM_WORDS   (4096),
    .WAIT_STATES (WS),
    .LED_WIDTH   (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ldst      (ldst),
    .o_ledr    (ledr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          e;
  int          cyc_base = 0;
  logic [15:0] ram_m [4096];
  logic [9:0]  led_m = '0;
  logic [15:0] scr_m [8];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd = '0;
  logic [15:0] mon_d;
  logic [15:0] unm [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) e <= 0;
    else       e <= e + 1;
  end

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] wa;
    wa = {a[15:1], 1'b0};
    if (wa < 16'h2000)         return ram_m[wa[12:1]];
    if (wa == 16'h2000)        return {6'b0, led_m};
    if (wa == 16'h2002)        return 16'(e - cyc_base);
    if (wa[15:4] == 12'h300)   return scr_m[wa[3:1]];
    return 16'h0000;
  endfunction

  function automatic int model_cycles_next();
    return (e - cyc_base) & 16'hFFFF;
  endfunction

  task automatic model_apply(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] wa;
    wa = {a[15:1], 1'b0};
    if (wr) begin
      if (wa < 16'h2000)            ram_m[wa[12:1]] = d;
      else if (wa == 16'h2000)      led_m = d[9:0];
      else if (wa == 16'h2002)      cyc_base = e + 1;
      else if (wa[15:4] == 12'h300) scr_m[wa[3:1]] = d;
    end else if (rd) begin
      exp_q.push_back(model_read(a));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    ldst.i_ldst_rd = 1'b0;
    ldst.i_ldst_wr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request, waits for acceptance (bounded), leaves inputs driven for the caller.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int   stalls;
    bit   ok;
    logic w;
    int   exp_stall;
    exp_stall          = (a[15:4] == 12'h300) ? WS : 0;
    ldst.i_ldst_rd     = rd;
    ldst.i_ldst_wr     = wr;
    ldst.i_ldst_addr   = a;
    ldst.i_ldst_wrdata = d;
    stalls = 0;
    ok     = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      w = ldst.o_ldst_waitrequest;
      @(posedge clk);
      if (w === 1'b0) begin
        ok = 1'b1;
        model_apply(rd, wr, a, d);
      end else begin
        stalls++;
      end
    end
    #1;
    check("accept", 32'(ok), 32'(1'b1));
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("rdvalid", 32'(ldst.o_ldst_rdvalid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        mon_d = exp_q.pop_front();
        check("rddata", 32'(ldst.o_ldst_rddata), 32'(mon_d));
        last_rd = mon_d;
      end else begin
        check("rddata_hold", 32'(ldst.o_ldst_rddata), 32'(last_rd));
      end
      check("ledr", 32'(ledr), 32'(led_m));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          sel, kind, g;
    logic [15:0] a;
    logic        rd, wr;

    unm[0] = 16'h2100; unm[1] = 16'h2004; unm[2] = 16'h4000; unm[3] = 16'hFFFE;
    for (int i = 0; i < 8; i++) scr_m[i] = '0;
    reset = 1'b1;
    ldst.i_ldst_rd = 1'b0; ldst.i_ldst_wr = 1'b0;
    ldst.i_ldst_addr = '0; ldst.i_ldst_wrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rddata", 32'(ldst.o_ldst_rddata), 32'h0000);
    check("reset_rdvalid", 32'(ldst.o_ldst_rdvalid), 32'h0);
    check("reset_waitreq", 32'(ldst.o_ldst_waitrequest), 32'h0);
    check("reset_ledr", 32'(ledr), 32'h000);
    reset = 1'b0;

    // cycle counter 5 edges after reset
    idle(5);
    issue(1, 0, 16'h2002, 16'h0);

    // store then back-to-back load to RAM
    issue(0, 1, 16'h0010, 16'h1234);
    issue(1, 0, 16'h0010, 16'h0);
    idle(2);

    // LED register, unmapped read, odd-address read
    issue(0, 1, 16'h2000, 16'h03FF);
    idle(1);
    issue(1, 0, 16'h2000, 16'h0);
    issue(1, 0, 16'h2100, 16'h0);
    issue(1, 0, 16'h2001, 16'h0);
    idle(1);

    // slow region store and load
    issue(0, 1, 16'h3004, 16'hBEEF);
    issue(1, 0, 16'h3004, 16'h0);
    idle(2);

    // counter clear, then run to wrap
    issue(0, 1, 16'h2002, 16'h5A5A);
    issue(1, 0, 16'h2002, 16'h0);
    idle(0);
    for (g = 0; g < 70000 && model_cycles_next() != 16'hFFFF; g++) begin
      @(posedge clk);
      #1;
    end
    check("wrap_reached", 32'(model_cycles_next()), 32'hFFFF);
    issue(1, 0, 16'h2002, 16'h0);
    issue(1, 0, 16'h2002, 16'h0);
    idle(2);

    // rd and wr together: store only
    issue(1, 1, 16'h0020, 16'h00AA);
    idle(2);
    issue(1, 0, 16'h0020, 16'h0);
    idle(2);

    // slow request dropped during WAIT: no write
    ldst.i_ldst_addr = 16'h3006; ldst.i_ldst_wrdata = 16'h7777;
    ldst.i_ldst_rd = 1'b0; ldst.i_ldst_wr = 1'b1;
    @(negedge clk);
    check("abort_req_wait", 32'(ldst.o_ldst_waitrequest), 32'h1);
    @(posedge clk); #1;
    ldst.i_ldst_wr = 1'b0;
    @(negedge clk);
    check("abort_dropped_wait", 32'(ldst.o_ldst_waitrequest), 32'h0);
    idle(2);
    issue(1, 0, 16'h3006, 16'h0);
    idle(2);

    // randomized mix
    for (int i = 0; i < 16; i++) issue(0, 1, 16'(16'h0100 + 2 * i), 16'($urandom));
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 9: a = 16'(16'h0100 + 2 * $urandom_range(0, 15) + $urandom_range(0, 1));
        4:             a = 16'h2000;
        5:             a = 16'h2002;
        6, 7:          a = 16'(16'h3000 + 2 * $urandom_range(0, 7));
        default:       a = unm[$urandom_range(0, 3)];
      endcase
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      issue(rd, wr, a, 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    // reset during a stalled slow store
    ldst.i_ldst_addr = 16'h3004; ldst.i_ldst_wrdata = 16'h5555;
    ldst.i_ldst_rd = 1'b0; ldst.i_ldst_wr = 1'b1;
    @(negedge clk);
    check("rst_req_wait", 32'(ldst.o_ldst_waitrequest), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_wait", 32'(ldst.o_ldst_waitrequest), 32'h1);
    #2;
    reset = 1'b1;
    ldst.i_ldst_wr = 1'b0;
    led_m = '0;
    for (int i = 0; i < 8; i++) scr_m[i] = '0;
    cyc_base = 0;
    exp_q.delete();
    last_rd = '0;
    #1;
    check("rst_waitreq", 32'(ldst.o_ldst_waitrequest), 32'h0);
    check("rst_rdvalid", 32'(ldst.o_ldst_rdvalid), 32'h0);
    check("rst_rddata", 32'(ldst.o_ldst_rddata), 32'h0000);
    check("rst_ledr", 32'(ledr), 32'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1, 0, 16'h3004, 16'h0);
    issue(1, 0, 16'h2000, 16'h0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
